shift_left_seq: RTL and testbench

- Iterative 32-bit logical left shifter for the ALU's SLL path. It is the opposite-direction counterpart of the combinational right-shift mux levels.
- Processes one bit of the shift amount per clock, levels 1, 2, 4, 8, 16, with zero fill from the LSB.
- Start/busy/done handshake with fixed latency, so the ALU controller can share one shifter datapath over several cycles.
- Also reports whether any 1-bit was shifted out (lost-bits flag).

---
 rtl/shift_left_seq_pkg.sv | 15 +
 rtl/shift_left_seq_shl_level.sv | 17 +
 rtl/shift_left_seq.sv | 105 ++++++++++
 tb/tb_shift_left_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_left_seq_pkg.sv
// Shared types and helpers for the iterative left shifter.
package shift_left_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of the level counter; a single-level shifter still needs one bit.
  function automatic int unsigned lvl_width(input int unsigned shw);
    return (shw > 1) ? $clog2(shw) : 1;
  endfunction

endpackage

// File: rtl/shift_left_seq_shl_level.sv
// One power-of-two left-shift level with zero fill and a shifted-out-ones flag.
module shl_level #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0
) (
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             out
);

  localparam int unsigned S = 1 << K;

  assign y   = en ? (x << S) : x;
  assign out = en & (|x[WIDTH-1 -: S]);

endmodule

// File: rtl/shift_left_seq.sv
// Iterative logical left shifter: one shift-amount bit per clock, fixed latency,
// start/busy/done handshake and a sticky flag for any 1-bit shifted out.
module shift_left_seq
  import shift_left_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] R,
  output logic             lost,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LVW = lvl_width(SHW);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             lost_q, lost_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [LVW-1:0]   lvl_q, lvl_d;

  logic [WIDTH-1:0] lvl_y [SHW];
  logic [SHW-1:0]   lvl_out;
  logic [WIDTH-1:0] sel_y;
  logic             sel_out;

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    shl_level #(
      .WIDTH(WIDTH),
      .K    (k)
    ) u_lvl (
      .x  (r_q),
      .en (shamt_q[k]),
      .y  (lvl_y[k]),
      .out(lvl_out[k])
    );
  end

  // All levels see the same register; the counter picks the one active this cycle.
  always_comb begin
    sel_y   = r_q;
    sel_out = 1'b0;
    for (int unsigned k = 0; k < SHW; k++) begin
      if (lvl_q == LVW'(k)) begin
        sel_y   = lvl_y[k];
        sel_out = lvl_out[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    lost_d  = lost_q;
    shamt_d = shamt_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = A;
          shamt_d = shamt;
          lost_d  = 1'b0;
          lvl_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d    = sel_y;
        lost_d = lost_q | sel_out;
        lvl_d  = lvl_q + LVW'(1);
        if (lvl_q == LVW'(SHW - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      lost_q  <= 1'b0;
      shamt_q <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      lost_q  <= lost_d;
      shamt_q <= shamt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign R    = r_q;
  assign lost = lost_q;
  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: driver pushes model results, monitor checks on done.
module tb_shift_left_seq;

  localparam int SHW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic [31:0] R;
  logic        lost;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] r;
    logic        lost;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] last_r = '0;
  logic        last_lost = 1'b0;

  shift_left_seq #(
    .WIDTH(32),
    .SHW  (SHW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .shamt(shamt),
    .R    (R),
    .lost (lost),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: shift in a double-width word; anything above bit 31 was lost.
  function automatic void model(input logic [31:0] a, input int unsigned sh,
                                output logic [31:0] r, output logic l);
    logic [63:0] w;
    w = {32'b0, a} << sh;
    r = w[31:0];
    l = |w[63:32];
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: done=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("R", R, e.r);
        check("lost", lost, e.lost);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // ign bit k asserts a stray start in operation cycle k (1..6).
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [7:0] ign);
    exp_t e;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("hold_R", R, last_r);
    check("hold_lost", lost, last_lost);
    start = 1'b1;
    A     = a;
    shamt = sh;
    @(posedge clk);
    #1;
    model(a, sh, e.r, e.lost);
    e.cyc = cyc + SHW;
    sb.push_back(e);
    last_r    = e.r;
    last_lost = e.lost;
    start = 1'b0;
    A     = $urandom;
    shamt = 5'($urandom);
    for (int k = 1; k <= SHW + 1; k++) begin
      @(negedge clk);
      check("op_busy", busy, 1);
      check("op_done", done, (k == SHW + 1));
      start = ign[k];
      if (ign[k]) begin
        A     = $urandom;
        shamt = 5'($urandom);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    A     = 32'hCAFE_F00D;
    shamt = 5'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_R", R, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    reset = 1'b0;
    start = 1'b0;

    run_op(32'h0000_0001, 5'd31, 8'h00);
    run_op(32'hDEAD_BEEF, 5'd4, 8'h00);
    run_op(32'h1234_5678, 5'd0, 8'h00);
    run_op(32'hFFFF_FFFF, 5'd31, 8'h00);
    run_op(32'hA5A5_0F0F, 5'd13, 8'b0100_0100);
    run_op(32'h8000_0000, 5'd1, 8'h00);

    // Abort mid-shift: reset sampled at the end of SHIFT cycle 3.
    @(negedge clk);
    start = 1'b1;
    A     = 32'hFFFF_FFFF;
    shamt = 5'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_R", R, 0);
    check("abort_lost", lost, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    reset     = 1'b0;
    last_r    = '0;
    last_lost = 1'b0;
    run_op(32'hFFFF_FFFF, 5'd7, 8'h00);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 1) == 1) ? (8'($urandom) & 8'h7E) : 8'h00;
      run_op($urandom, 5'($urandom), m);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results never signalled done", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
